// File: rtl/param_processor_pkg.sv
// Shared types and field widths for the parameterised multi-cycle processor.
// The optional flag port is enabled by the PARAM_PROCESSOR_FLAGS_EN macro.
package param_processor_pkg;

    localparam int OPC_W = 3;

    typedef enum logic [2:0] {
        OP_MV   = 3'b000,
        OP_MVI  = 3'b001,
        OP_ADD  = 3'b010,
        OP_SUB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_MVNZ = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_e;

endpackage

// File: rtl/param_processor_alu.sv
// Combinational ALU: add/sub wrap modulo 2^DATA_W; carry is carry-out for add,
// borrow for sub and 0 for the logic ops.
module param_processor_alu
    import param_processor_pkg::*;
#(
    parameter int DATA_W = 9
) (
    input  op_e               op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    always_comb begin
        result = '0;
        carry  = 1'b0;
        case (op)
            OP_ADD:  {carry, result} = {1'b0, a} + {1'b0, b};
            OP_SUB:  {carry, result} = {1'b0, a} - {1'b0, b};
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            default: ;
        endcase
    end

endmodule

// File: rtl/param_processor.sv
// Multi-cycle register processor (T0 fetch, T1-T3 execute) with a shared bus.
// Define PARAM_PROCESSOR_FLAGS_EN to add the {C, Z} Flags output.
module param_processor
    import param_processor_pkg::*;
#(
    parameter int DATA_W = 9,
    parameter int NREGS  = 8
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              Run,
    input  logic [DATA_W-1:0] DIN,
    output logic [DATA_W-1:0] Bus,
    output logic              Done
`ifdef PARAM_PROCESSOR_FLAGS_EN
    ,
    output logic [1:0]        Flags
`endif
);

    localparam int REG_AW = $clog2(NREGS);
    localparam int IR_W   = OPC_W + 2 * REG_AW;

    state_e                       state_q, state_d;
    logic [IR_W-1:0]              ir_q, ir_d;
    logic [DATA_W-1:0]            a_q, a_d;
    logic [DATA_W-1:0]            g_q, g_d;
    logic [NREGS-1:0][DATA_W-1:0] regs_q, regs_d;

    op_e               opc;
    logic [REG_AW-1:0] rx, ry;
    logic [DATA_W-1:0] bus, alu_res;
    logic              alu_carry, done;

    // Only the opcode and register fields are kept; trailing DIN bits are ignored.
    assign opc = op_e'(ir_q[IR_W-1 -: OPC_W]);
    assign rx  = ir_q[IR_W-OPC_W-1 -: REG_AW];
    assign ry  = ir_q[REG_AW-1:0];

    param_processor_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (opc),
        .a      (a_q),
        .b      (regs_q[ry]),
        .result (alu_res),
        .carry  (alu_carry)
    );

`ifdef PARAM_PROCESSOR_FLAGS_EN
    logic [1:0] flags_q, flags_d;
`else
    logic unused_carry;
    assign unused_carry = alu_carry;
`endif

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        a_d     = a_q;
        g_d     = g_q;
        regs_d  = regs_q;
        bus     = '0;
        done    = 1'b0;
`ifdef PARAM_PROCESSOR_FLAGS_EN
        flags_d = flags_q;
`endif
        case (state_q)
            T0: begin
                if (Run) begin
                    ir_d    = DIN[DATA_W-1 -: IR_W];
                    state_d = T1;
                end
            end
            T1: begin
                case (opc)
                    OP_MV, OP_MVNZ: begin
                        bus = regs_q[ry];
                        if (opc == OP_MV || g_q != '0) regs_d[rx] = bus;
                        done    = 1'b1;
                        state_d = T0;
                    end
                    OP_MVI: begin
                        bus        = DIN;
                        regs_d[rx] = bus;
                        done       = 1'b1;
                        state_d    = T0;
                    end
                    default: begin
                        bus     = regs_q[rx];
                        a_d     = bus;
                        state_d = T2;
                    end
                endcase
            end
            T2: begin
                bus     = regs_q[ry];
                g_d     = alu_res;
`ifdef PARAM_PROCESSOR_FLAGS_EN
                flags_d = {alu_carry, alu_res == '0};
`endif
                state_d = T3;
            end
            T3: begin
                // Rx is written only here, after both operands were read, so Rx == Ry is safe.
                bus        = g_q;
                regs_d[rx] = g_q;
                done       = 1'b1;
                state_d    = T0;
            end
            default: state_d = T0;
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= T0;
            ir_q    <= '0;
            a_q     <= '0;
            g_q     <= '0;
            regs_q  <= '0;
`ifdef PARAM_PROCESSOR_FLAGS_EN
            flags_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            a_q     <= a_d;
            g_q     <= g_d;
            regs_q  <= regs_d;
`ifdef PARAM_PROCESSOR_FLAGS_EN
            flags_q <= flags_d;
`endif
        end
    end

    assign Bus  = Reset ? '0 : bus;
    assign Done = Reset ? 1'b0 : done;
`ifdef PARAM_PROCESSOR_FLAGS_EN
    assign Flags = flags_q;
`endif

endmodule

// File: tb/tb_param_processor.sv
// Directed bench for param_processor (DATA_W=9, NREGS=8) with an ISA-level model
// and a scoreboard of instruction results checked whenever Done is high.
module tb_param_processor;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Run   = 1'b0;
    logic [8:0] DIN   = '0;
    logic [8:0] Bus;
    logic       Done;
`ifdef PARAM_PROCESSOR_FLAGS_EN
    logic [1:0] Flags;
`endif

    param_processor #(.DATA_W(9), .NREGS(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .Run   (Run),
        .DIN   (DIN),
        .Bus   (Bus),
        .Done  (Done)
`ifdef PARAM_PROCESSOR_FLAGS_EN
        ,
        .Flags (Flags)
`endif
    );

    always #5 Clock = ~Clock;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] sb[$];
    logic [8:0] m_regs[8];
    logic [8:0] m_g;
    logic [1:0] m_flags;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Every Done must match the oldest outstanding instruction result.
    always @(negedge Clock) begin
        if (Done === 1'b1) begin
            if (sb.size() == 0) begin
                check("spurious_done", Bus, 9'h1FF ^ Bus);
            end else begin
                check("sb_result", Bus, sb.pop_front());
            end
        end
    end

    task automatic model_reset();
        foreach (m_regs[i]) m_regs[i] = '0;
        m_g     = '0;
        m_flags = '0;
    endtask

    task automatic exec(input logic [8:0] instr, input logic [8:0] imm, input bit keep_run);
        logic [2:0] opc;
        int         rx, ry;
        logic [8:0] a, b, res;
        logic       c;
        opc = instr[8:6];
        rx  = int'(instr[5:3]);
        ry  = int'(instr[2:0]);
        Run = 1'b1;
        DIN = instr;
        @(negedge Clock);
        check("t0_bus", Bus, 9'h000);
        check("t0_done", {8'h0, Done}, 9'h000);
        @(posedge Clock); #1;
        Run = keep_run;
        DIN = imm;
        case (opc)
            3'b000, 3'b001, 3'b111: begin
                res = (opc == 3'b001) ? imm : m_regs[ry];
                sb.push_back(res);
                @(negedge Clock);
                check("t1_bus", Bus, res);
                check("t1_done", {8'h0, Done}, 9'h001);
                if (opc != 3'b111 || m_g != '0) m_regs[rx] = res;
            end
            default: begin
                a = m_regs[rx];
                b = m_regs[ry];
                c = 1'b0;
                case (opc)
                    3'b010:  {c, res} = {1'b0, a} + {1'b0, b};
                    3'b011:  {c, res} = {1'b0, a} - {1'b0, b};
                    3'b100:  res = a & b;
                    3'b101:  res = a | b;
                    default: res = a ^ b;
                endcase
                @(negedge Clock);
                check("alu_t1_bus", Bus, a);
                check("alu_t1_done", {8'h0, Done}, 9'h000);
                @(posedge Clock); #1;
                @(negedge Clock);
                check("alu_t2_bus", Bus, b);
                check("alu_t2_done", {8'h0, Done}, 9'h000);
                @(posedge Clock); #1;
                m_g     = res;
                m_flags = {c, res == 9'h000};
                sb.push_back(res);
                @(negedge Clock);
                check("alu_t3_bus", Bus, res);
`ifdef PARAM_PROCESSOR_FLAGS_EN
                check("alu_flags", {7'h0, Flags}, {7'h0, m_flags});
`endif
                m_regs[rx] = res;
            end
        endcase
        @(posedge Clock); #1;
    endtask

    function automatic logic [8:0] ins(input logic [2:0] op, input logic [2:0] rx, input logic [2:0] ry);
        return {op, rx, ry};
    endfunction

    initial begin
        model_reset();
        @(negedge Clock);
        check("rst_bus", Bus, 9'h000);
        check("rst_done", {8'h0, Done}, 9'h000);
        #3 Reset = 1'b0;
        @(posedge Clock); #1;

        // Idle with Run low: no fetch, no Done.
        repeat (2) begin
            @(negedge Clock);
            check("idle_bus", Bus, 9'h000);
            @(posedge Clock); #1;
        end

        exec(9'b001_000_000, 9'd5, 1'b0);              // mvi R0,5
        exec(ins(3'b000, 3'd7, 3'd0), 9'h0, 1'b0);     // mv R7,R0 -> 5
        exec(ins(3'b001, 3'd1, 3'd0), 9'd3, 1'b0);     // mvi R1,3
        exec(9'b010_000_001, 9'h0, 1'b0);              // add R0,R1 -> 8
        exec(ins(3'b000, 3'd7, 3'd0), 9'h0, 1'b0);     // read back R0

        exec(ins(3'b001, 3'd0, 3'd0), 9'd3, 1'b0);
        exec(ins(3'b001, 3'd1, 3'd0), 9'd5, 1'b0);
        exec(ins(3'b011, 3'd0, 3'd1), 9'h0, 1'b0);     // sub -> 1FE, borrow
        exec(ins(3'b000, 3'd7, 3'd0), 9'h0, 1'b0);

        exec(ins(3'b110, 3'd3, 3'd3), 9'h0, 1'b0);     // xor R3,R3 -> G=0
        exec(ins(3'b001, 3'd0, 3'd0), 9'd7, 1'b0);
        exec(ins(3'b111, 3'd2, 3'd0), 9'h0, 1'b0);     // mvnz, G=0: no write
        exec(ins(3'b000, 3'd7, 3'd2), 9'h0, 1'b0);
        exec(ins(3'b001, 3'd4, 3'd0), 9'd1, 1'b0);
        exec(ins(3'b101, 3'd4, 3'd5), 9'h0, 1'b0);     // or -> G=1
        exec(ins(3'b111, 3'd2, 3'd0), 9'h0, 1'b0);     // mvnz, G!=0: R2=7
        exec(ins(3'b000, 3'd7, 3'd2), 9'h0, 1'b0);

        exec(ins(3'b001, 3'd1, 3'd0), 9'h1FF, 1'b0);
        exec(ins(3'b001, 3'd6, 3'd0), 9'd2, 1'b0);
        exec(ins(3'b010, 3'd1, 3'd6), 9'h0, 1'b0);     // add wraps with carry
        exec(ins(3'b010, 3'd0, 3'd0), 9'h0, 1'b0);     // add R0,R0 doubles
        exec(ins(3'b000, 3'd7, 3'd0), 9'h0, 1'b0);

        // Run held high: back-to-back mvi, and Run high through an ALU op.
        exec(ins(3'b001, 3'd5, 3'd0), 9'h0AA, 1'b1);
        exec(ins(3'b001, 3'd6, 3'd0), 9'h155, 1'b1);
        exec(ins(3'b100, 3'd5, 3'd6), 9'h0, 1'b1);
        exec(ins(3'b000, 3'd7, 3'd6), 9'h0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            exec(ins(3'b001, i[2:0], 3'd0), 9'($urandom_range(0, 511)), 1'b0);
        end
        for (int i = 0; i < 8; i++) begin
            exec(ins(3'($urandom_range(2, 6)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7))),
                 9'h0, 1'($urandom_range(0, 1)));
        end
        Run = 1'b0;

        // Reset in T2 of add R0,R1 abandons the instruction.
        exec(ins(3'b001, 3'd0, 3'd0), 9'd9, 1'b0);
        exec(ins(3'b001, 3'd1, 3'd0), 9'd4, 1'b0);
        Run = 1'b1;
        DIN = ins(3'b010, 3'd0, 3'd1);
        @(posedge Clock); #1;
        Run = 1'b0;
        @(posedge Clock); #1;
        Reset = 1'b1;
        #1;
        check("midrst_bus", Bus, 9'h000);
        check("midrst_done", {8'h0, Done}, 9'h000);
        @(negedge Clock);
        check("midrst_done_neg", {8'h0, Done}, 9'h000);
        @(posedge Clock); #1;
        Reset = 1'b0;
        model_reset();
        @(negedge Clock);
        check("postrst_bus", Bus, 9'h000);
        check("postrst_done", {8'h0, Done}, 9'h000);
`ifdef PARAM_PROCESSOR_FLAGS_EN
        check("postrst_flags", {7'h0, Flags}, 9'h000);
`endif
        @(posedge Clock); #1;
        exec(ins(3'b000, 3'd7, 3'd0), 9'h0, 1'b0);
        exec(ins(3'b000, 3'd7, 3'd1), 9'h0, 1'b0);
        exec(ins(3'b111, 3'd3, 3'd7), 9'h0, 1'b0);     // G cleared by reset
        exec(ins(3'b010, 3'd0, 3'd1), 9'h0, 1'b0);
        Run = 1'b0;
        repeat (2) @(posedge Clock);
        #1;

        check("sb_drained", 9'(sb.size()), 9'h000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/param_processor.md
PARAM_PROCESSOR -- requirements
Module: param_processor

Interface
REQ-001 SHALL provide parameter DATA_W, default 9, meaning width of DIN, Bus, registers and instruction word.
REQ-002 SHALL provide parameter NREGS, default 8, meaning number of general registers (power of 2); REG_AW = clog2(NREGS); DATA_W >= 3 + 2*REG_AW.
REQ-003 SHALL provide port Clock  input  1  single clock, all state on rising edge.
REQ-004 SHALL provide port Reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL provide port Run  input  1  start request, sampled only in state T0.
REQ-006 SHALL provide port DIN  input  DATA_W  instruction word in T0; immediate operand in T1 of mvi.
REQ-007 SHALL provide port Bus  output  DATA_W  current internal bus value.
REQ-008 SHALL provide port Done  output  1  high during the final step of an instruction.

Function
REQ-009 SHALL decode instructions as opcode = DIN[DATA_W-1 -: 3], Rx = next REG_AW bits, Ry = next REG_AW bits; remaining low bits ignored.
REQ-010 SHALL implement opcodes 000 mv, 001 mvi, 010 add, 011 sub, 100 and, 101 or, 110 xor, 111 mvnz.
REQ-011 SHALL use states T0, T1, T2, T3; T0 loads IR from DIN when Run=1, else stays in T0.
REQ-012 SHALL complete mv (Rx<=Ry), mvi (Rx<=DIN) and mvnz (Rx<=Ry only if G != 0) in T1, Done=1, then T0.
REQ-013 SHALL execute ALU ops as T1 A<=Rx, T2 G<=A op Ry, T3 Rx<=G with Done=1, then T0.
REQ-014 SHALL drive Bus: 0 in T0; Ry in T1 of mv/mvnz; DIN in T1 of mvi; Rx in T1, Ry in T2, G in T3 of ALU ops.
REQ-015 SHALL compute add/sub modulo 2^DATA_W (wrap-around, no saturation).
REQ-016 SHALL ignore Run in T1-T3; Run held high fetches a new instruction in the T0 following Done.
REQ-017 SHALL permit Rx == Ry; the result is written after operand read (add R0,R0 doubles R0).

Reset
REQ-018 SHALL on Reset force state T0 and clear IR, A, G and all registers to 0 regardless of current state.
REQ-019 SHALL hold Done=0 and Bus=0 while Reset is high; a mid-instruction Reset abandons that instruction with no register write.

Configuration
REQ-020 SHALL, with PARAM_PROCESSOR_FLAGS_EN defined, add output port Flags [1:0] = {C, Z}, updated in T2 of ALU ops (Z = result==0; C = carry-out for add, borrow for sub, 0 for logic ops), reset to 0.
REQ-021 SHALL, without PARAM_PROCESSOR_FLAGS_EN, omit the Flags port and flag logic entirely; all other behaviour is unchanged.

Structure
REQ-022 SHALL place the opcode enum, state enum and field-width constants in package param_processor_pkg.
REQ-023 SHALL implement the combinational ALU (op, a, b -> result, carry) as sub-module param_processor_alu.

Verification (DATA_W=9, NREGS=8)
REQ-024 Reset; DIN=9'b001_000_000 with Run, next cycle DIN=5 -> Done=1 and Bus=5 in T1; R0=5.
REQ-025 R0=5, R1=3; add R0,R1 (9'b010_000_001) -> Bus=5,3,8 in T1-T3, Done only in T3, R0=8.
REQ-026 R0=3, R1=5; sub R0,R1 -> R0=9'h1FE; with FLAGS_EN, Flags=2'b10.
REQ-027 G=0, R0=7; mvnz R2,R0 -> Done in T1, R2 unchanged; repeat after G=1 -> R2=7.
REQ-028 Reset asserted in T2 of add -> Done=0, state T0, all registers 0 on the next cycle, no write to Rx.
REQ-029 Run held high across two back-to-back mvi instructions -> exactly one Done per instruction, second IR loaded in the T0 after the first Done.
